ysyx_22041412_div_unit: RTL and testbench

- Multi-cycle RV64M divide responder.
- Accepts a request from the EXU issue side over a valid/ready handshake.
- Runs a radix-2 restoring division and returns the quotient or remainder over a second valid/ready handshake.
- Covers DIV/DIVU/REM/REMU and the W variants, replacing the single-cycle combinational "/" path in the EXU.

---
 rtl/ysyx_22041412_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_22041412_div_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_div_unit.sv
// ysyx_22041412_div_unit
//   Multi-cycle RV64M divider: DIV/DIVU/REM/REMU and the W forms, using a
//   radix-2 restoring algorithm (one quotient bit per clock).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           aborts any in-flight op; drops a same-cycle request
//   in_valid/ready  request handshake (in_ready is high only in IDLE)
//   rsA, rsB        dividend / divisor
//   func3           100 DIV, 101 DIVU, 110 REM, 111 REMU; others return 0
//   is_word         selects the 32-bit W form (result sign-extended from bit 31)
//   out_valid/ready result handshake; data is held stable until taken
//   data            quotient or remainder; keeps last delivered value otherwise
//
// Build option
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| finishes at accept
//                     (quotient 0, remainder = dividend). Results are unchanged,
//                     only latency differs.
module ysyx_22041412_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rsA,
  input  logic [XLEN-1:0] rsB,
  input  logic [2:0]      func3,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Word forms: extend bits [HALF-1:0], sign- or zero-filling the upper half.
  function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v,
                                               input logic sgn,
                                               input logic word);
    if (!word) return v;
    return {{HALF{sgn & v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Two's-complement negate when requested (magnitude extraction / sign fix).
  function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] v,
                                               input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_p1, quo_p1, dvsr_p1;
  logic             neg_q_p1, neg_r_p1, sel_rem_p1, word_p1;

  // ---- p0: operand preparation at accept ----
  logic                   signed_op_p0, legal_p0;
  logic signed [XLEN-1:0] a_ext_p0, b_ext_p0, int_min_p0;
  logic                   a_neg_p0, b_neg_p0;
  logic [XLEN-1:0]        a_mag_p0, b_mag_p0;
  logic                   div_zero_p0, ovf_p0, early_p0, special_p0;
  logic [XLEN-1:0]        quo_sp_p0, rem_sp_p0, sp_res_p0;

  assign signed_op_p0 = ~func3[0];
  assign legal_p0     = func3[2];
  assign a_ext_p0     = signed'(ext_word(rsA, signed_op_p0, is_word));
  assign b_ext_p0     = signed'(ext_word(rsB, signed_op_p0, is_word));
  assign a_neg_p0     = signed_op_p0 & a_ext_p0[XLEN-1];
  assign b_neg_p0     = signed_op_p0 & b_ext_p0[XLEN-1];
  assign a_mag_p0     = fix_sign(a_ext_p0, a_neg_p0);
  assign b_mag_p0     = fix_sign(b_ext_p0, b_neg_p0);
  assign int_min_p0   = is_word ? signed'({{(HALF+1){1'b1}}, {(HALF-1){1'b0}}})
                                : signed'({1'b1, {(XLEN-1){1'b0}}});
  assign div_zero_p0  = (b_ext_p0 == '0);
  assign ovf_p0       = signed_op_p0 & (a_ext_p0 == int_min_p0) & (b_ext_p0 == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early_p0 = ~div_zero_p0 & (a_mag_p0 < b_mag_p0);
`else
  assign early_p0 = 1'b0;
`endif

  assign special_p0 = div_zero_p0 | ovf_p0 | early_p0;

  always_comb begin
    quo_sp_p0 = '0;
    rem_sp_p0 = a_ext_p0;
    if (div_zero_p0) begin
      quo_sp_p0 = '1;
    end else if (ovf_p0) begin
      quo_sp_p0 = a_ext_p0;
      rem_sp_p0 = '0;
    end
  end

  assign sp_res_p0 = ext_word(func3[1] ? rem_sp_p0 : quo_sp_p0, 1'b1, is_word);

  // ---- p1: one restoring step per cycle ----
  logic [XLEN:0]   shifted_p1;
  logic            fits_p1;
  logic [XLEN-1:0] trial_p1, rem_nxt_p1, quo_nxt_p1, res_p1;

  assign shifted_p1 = {rem_p1, quo_p1[XLEN-1]};
  assign fits_p1    = (shifted_p1 >= {1'b0, dvsr_p1});
  assign trial_p1   = shifted_p1[XLEN-1:0] - dvsr_p1;
  assign rem_nxt_p1 = fits_p1 ? trial_p1 : shifted_p1[XLEN-1:0];
  assign quo_nxt_p1 = {quo_p1[XLEN-2:0], fits_p1};
  assign res_p1     = ext_word(sel_rem_p1 ? fix_sign(rem_nxt_p1, neg_r_p1)
                                          : fix_sign(quo_nxt_p1, neg_q_p1),
                               1'b1, word_p1);

  // ---- control and result registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      data       <= '0;
      cnt        <= '0;
      rem_p1     <= '0;
      quo_p1     <= '0;
      dvsr_p1    <= '0;
      neg_q_p1   <= 1'b0;
      neg_r_p1   <= 1'b0;
      sel_rem_p1 <= 1'b0;
      word_p1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            in_ready <= 1'b0;
            if (!legal_p0) begin
              data      <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (special_p0) begin
              data      <= sp_res_p0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // Word dividends sit in the upper half so HALF shifts consume them.
              quo_p1     <= is_word ? (a_mag_p0 << HALF) : a_mag_p0;
              rem_p1     <= '0;
              dvsr_p1    <= b_mag_p0;
              cnt        <= is_word ? CNT_W'(HALF) : CNT_W'(XLEN);
              neg_q_p1   <= a_neg_p0 ^ b_neg_p0;
              neg_r_p1   <= a_neg_p0;
              sel_rem_p1 <= func3[1];
              word_p1    <= is_word;
              state      <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            rem_p1 <= rem_nxt_p1;
            quo_p1 <= quo_nxt_p1;
            cnt    <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              data      <= res_p1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_div_unit.sv
module tb_ysyx_22041412_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rsA, rsB;
  logic [2:0]  func3;
  logic        is_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data;

  int vectors = 0;
  int miscompares = 0;
  int lat;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 65;
`endif

  ysyx_22041412_div_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rsA(rsA), .rsB(rsB), .func3(func3), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready), .data(data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input logic w);
    @(negedge clk);
    rsA = a; rsB = b; func3 = f3; is_word = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input logic w,
                       input logic [63:0] exp_data, input int exp_lat);
    check({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    issue(a, b, f3, w);
    wait_result();
    check({tag, " data"}, data, exp_data);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    release_result(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rsA = '0; rsB = '0; func3 = 3'b100; is_word = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset data", data, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op("div -7/2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem -7/2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("divu",      64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b101, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    do_op("remu",      64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b111, 1'b0, 64'hF, 65);
    do_op("div by 0",  64'd5, 64'd0, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("remw by 0", 64'h1_8000_0000, 64'd0, 3'b110, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    do_op("div ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0,
          64'h8000_0000_0000_0000, 1);
    do_op("rem ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 64'd0, 1);
    do_op("divw ovf",  64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b1,
          64'hFFFF_FFFF_8000_0000, 1);
    do_op("div -100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 3'b100, 1'b0, 64'd14, 65);
    do_op("rem -100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 3'b110, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("divw -100/7", 64'hDEAD_BEEF_FFFF_FF9C, 64'h1234_5678_0000_0007, 3'b100, 1'b1,
          64'hFFFF_FFFF_FFFF_FFF2, 33);
    do_op("remw -100/7", 64'hDEAD_BEEF_FFFF_FF9C, 64'h1234_5678_0000_0007, 3'b110, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 33);
    do_op("div 3/-10", 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 3'b100, 1'b0, 64'd0, EARLY_LAT);
    do_op("rem -3/10", 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 3'b110, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFD, EARLY_LAT);
    do_op("divuw all1/1", 64'hFFFF_FFFF, 64'd1, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("illegal func3", 64'd40, 64'd5, 3'b000, 1'b0, 64'd0, 1);

    // Backpressure: result must hold while out_ready stays low.
    check("bp in_ready", {63'd0, in_ready}, 64'd1);
    issue(64'd100, 64'd7, 3'b101, 1'b0);
    wait_result();
    check("bp data", data, 64'hE);
    check("bp latency", 64'(lat), 64'd65);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold data", data, 64'hE);
      check("bp hold flags", {62'd0, out_valid, in_ready}, 64'd2);
    end
    release_result("bp");

    // Flush at CALC cycle 10.
    issue(64'd1000, 64'd3, 3'b100, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush flags", {62'd0, out_valid, in_ready}, 64'd1);
    repeat (80) @(posedge clk); #1;
    check("flush no result", {63'd0, out_valid}, 64'd0);
    check("flush data kept", data, 64'hE);

    // Flush together with a request drops the request.
    @(negedge clk);
    rsA = 64'd9; rsB = 64'd3; func3 = 3'b100; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    check("flush+accept in_ready", {63'd0, in_ready}, 64'd1);
    repeat (5) @(posedge clk); #1;
    check("flush+accept no result", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges in the middle of CALC.
    issue(64'd100, 64'd7, 3'b100, 1'b0);
    repeat (10) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    check("async rst flags", {62'd0, out_valid, in_ready}, 64'd1);
    check("async rst data", data, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op("divuw", 64'hFFFF_FFFF, 64'd3, 3'b101, 1'b1, 64'h0000_0000_5555_5555, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
